div512_seq: RTL
===============

# div512_seq

Sequential unsigned restoring divider for the MAC512 datapath, the inverse operation to the multiply-accumulate path. It computes one quotient bit per cycle with a single N+1-bit trial subtractor. A start/busy/done handshake wraps the computation, and results are held in output registers until the next operation. It divides accumulator results back down: normalization, scaling and modular reduction.

## Interface
- N, 512, operand width in bits (dividend, divisor, quotient, remainder)
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; accepted only when busy=0
- dividend  input  N  unsigned dividend, sampled on accepting edge only
- divisor  input  N  unsigned divisor, sampled on accepting edge only
- busy  output  1  high from the edge after acceptance until the done cycle ends
- done  output  1  one-cycle pulse; quotient/remainder valid from this cycle on
- quotient  output  N  registered quotient, held until next completion
- remainder  output  N  registered remainder, held until next completion
- div_by_zero  output  1  set with done when the sampled divisor was 0, held with results

## Operation
- Reset is asynchronous and active-low: clk is the only clock, and rst_n asserted low immediately forces state IDLE. All outputs and internal registers go to 0: busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0.
- States:
  - IDLE: waits for start.
  - CALC: iterates.
  - DONE: publishes results for one cycle, then returns to IDLE.
- IDLE, start=1:
  - If divisor!=0: load working quotient register Q=dividend, working remainder R (N+1 bits)=0, latched divisor D=divisor, counter=N-1, go to CALC.
  - If divisor==0: go directly to DONE with quotient=all ones, remainder=dividend, div_by_zero=1.
- CALC, each edge:
  - Shift: R' = {R[N-1:0], Q[N-1]}, Q' = {Q[N-2:0], 0}.
  - Trial: T = R' - {0,D} (N+1 bits).
  - If T[N]==0 (no borrow): R=T, Q[0]=1. Otherwise R=R', Q[0]=0.
  - When counter==0, go to DONE after this update. Otherwise decrement counter.
- Entering DONE: quotient<=Q, remainder<=R[N-1:0], div_by_zero<=0 (normal path). The output registers change only on entry to DONE.
- DONE: done=1, busy=0, next state IDLE. A start asserted during DONE is accepted exactly as in IDLE, allowing back-to-back operations.
- start while in CALC is ignored; there is no queuing. Operand inputs are don't-care except on the accepting edge.
- Results satisfy dividend = quotient*divisor + remainder, with remainder < divisor (divisor != 0).
- Reset asserted mid-CALC aborts the operation. No done pulse is produced and outputs return to 0.

## Timing
- Accepting edge E0 (start=1, state IDLE or DONE).
- Normal path: busy=1 during cycles E0+1 through E0+N. CALC occupies N edges, E0+1 … E0+N. done=1 in the cycle following edge E0+N, giving latency N+1 cycles (513 for N=512) from the accepting edge to done.
- Divide-by-zero path: done=1 in the cycle after E0, giving latency 1.
- busy and done are never high together. done is high for exactly one cycle per accepted start.
- Throughput with back-to-back starts: one result every N+1 cycles.
- Critical path is the one N+1-bit subtract plus mux per cycle. The trial subtractor may be built from the team's CLA adder tree with inverted D and carry-in 1.

## Test plan
- dividend=100, divisor=7, one start pulse -> done exactly 513 cycles after the accepting edge; quotient=14, remainder=2, div_by_zero=0; busy high for 512 cycles.
- dividend=2^512-1, divisor=1 -> quotient=2^512-1, remainder=0. Then dividend=2^512-1, divisor=2^512-1 -> quotient=1, remainder=0. Then dividend=5, divisor=2^511 -> quotient=0, remainder=5.
- dividend=0x1234, divisor=0 -> done one cycle after acceptance; quotient=all ones, remainder=0x1234, div_by_zero=1. The next normal division clears div_by_zero.
- start held high continuously with changing operands -> an operation is accepted only in IDLE/DONE cycles. Results match the operands sampled at each accepting edge, and done pulses every 513 cycles; mid-CALC operand changes have no effect.
- Start 100/7, then assert rst_n low at cycle 200 of CALC -> all outputs 0 immediately (asynchronous), no done pulse. After release, a new 9/3 start gives quotient=3, remainder=0.
- 1000 random N-bit pairs (including divisor > dividend and divisor with only the MSB set) checked against a reference model -> quotient and remainder exact, and the held outputs stay stable between done pulses.

Source files
------------

// File: rtl/div512_if.sv
// Handshake and operand/result bundle for the sequential divider.
interface div512_if #(
   parameter int N = 512
);
   logic         start;
   logic [N-1:0] dividend;
   logic [N-1:0] divisor;
   logic         busy;
   logic         done;
   logic [N-1:0] quotient;
   logic [N-1:0] remainder;
   logic         div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/div512_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock through a
// single N+1-bit trial subtractor, with a start/busy/done handshake.
module div512_seq #(
   parameter int N = 512
) (
   input  logic      clk,
   input  logic      rst_n,
   div512_if.slave   bus
);
   localparam int CW = $clog2(N);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_DONE
   } state_t;

   state_t        state_reg;
   logic [N-1:0]  q_reg;
   logic [N-1:0]  r_reg;
   logic [N-1:0]  d_reg;
   logic [CW-1:0] cnt_reg;
   logic          busy_reg;
   logic          done_reg;
   logic          dbz_reg;
   logic [N-1:0]  quo_reg;
   logic [N-1:0]  rem_reg;

   logic [N:0]    r_shift;
   logic [N:0]    trial;
   logic [N-1:0]  r_next;
   logic [N-1:0]  q_next;

   // The partial remainder never reaches D after a restoring step, so its
   // N+1-th bit is always 0 and is only materialised in the shifted value.
   always_comb begin
      r_shift = {r_reg, q_reg[N-1]};
      trial   = r_shift - {1'b0, d_reg};
      r_next  = trial[N] ? r_shift[N-1:0] : trial[N-1:0];
      q_next  = {q_reg[N-2:0], ~trial[N]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_IDLE;
         q_reg     <= '0;
         r_reg     <= '0;
         d_reg     <= '0;
         cnt_reg   <= '0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
         dbz_reg   <= 1'b0;
         quo_reg   <= '0;
         rem_reg   <= '0;
      end else begin
         unique case (state_reg)
            S_IDLE, S_DONE: begin
               if (bus.start && bus.divisor != '0) begin
                  q_reg     <= bus.dividend;
                  r_reg     <= '0;
                  d_reg     <= bus.divisor;
                  cnt_reg   <= CW'(N - 1);
                  busy_reg  <= 1'b1;
                  done_reg  <= 1'b0;
                  state_reg <= S_CALC;
               end else if (bus.start) begin
                  quo_reg   <= '1;
                  rem_reg   <= bus.dividend;
                  dbz_reg   <= 1'b1;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
                  state_reg <= S_DONE;
               end else begin
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b0;
                  state_reg <= S_IDLE;
               end
            end
            S_CALC: begin
               q_reg <= q_next;
               r_reg <= r_next;
               if (cnt_reg == '0) begin
                  quo_reg   <= q_next;
                  rem_reg   <= r_next;
                  dbz_reg   <= 1'b0;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
                  state_reg <= S_DONE;
               end else begin
                  cnt_reg <= cnt_reg - CW'(1);
               end
            end
            default: begin
               busy_reg  <= 1'b0;
               done_reg  <= 1'b0;
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy        = busy_reg;
   assign bus.done        = done_reg;
   assign bus.quotient    = quo_reg;
   assign bus.remainder   = rem_reg;
   assign bus.div_by_zero = dbz_reg;
endmodule
